fetch_stage: RTL and testbench
==============================

# fetch_stage

F-stage of the five-stage pipeline, directly upstream of the IF/ID register. It owns the program counter, selects the next PC (sequential, branch/jump redirect, exception entry, ERET return), fetches from instruction memory, and checks the fetch address for errors. It produces the instruction, PC, exception code and branch-delay flag that the IF/ID register latches each unfrozen cycle.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- frozen  in  1  pipeline stall; F and IF/ID hold.
- req  in  1  CP0 exception/interrupt entry; flushes and redirects to HANDLER_ADDR.
- eret_flush  in  1  ERET in D; redirect to epc.
- epc  in  32  return address from CP0.
- branch_taken  in  1  D-stage branch/jump resolved taken.
- branch_target  in  32  D-stage target address.
- is_branch_d  in  1  instruction in D is a branch or jump, including not-taken branches.
- i_inst_addr  out  32  instruction memory address (= pc).
- i_inst_rdata  in  32  instruction memory read data, combinational.
- instruction  out  32  fetched instruction to IF/ID.
- pc  out  32  PC of the fetched instruction.
- exc_code  out  5  fetch exception code: 5'd4 AdEL, 5'd31 none.
- BD  out  1  fetched instruction sits in a branch delay slot.

## Operation
- Single state register pc_r (32 bits). Everything else is combinational from pc_r and the inputs.
- Next-PC priority, highest first:
  1. req: HANDLER_ADDR.
  2. eret_flush: epc.
  3. frozen: hold pc_r.
  4. branch_taken: branch_target.
  5. otherwise: pc_r + 4.
- req and eret_flush override frozen.
- branch_taken is ignored while frozen; the branch is re-evaluated when D releases.
- pc_r + 4 wraps modulo 2^32 with no carry out. Wrap is not flagged separately; the out-of-range AdEL check catches it.
- Address check: AdEL when pc_r[1:0] != 0, pc_r < IM_LO, or pc_r > IM_HI (unsigned compare).
  - On AdEL: exc_code = 5'd4 and instruction forced to 32'h0 (nop). i_inst_addr still equals pc_r; memory reads are side-effect free.
  - Otherwise: exc_code = 5'd31 and instruction = i_inst_rdata.
- pc output is always pc_r, including the faulting PC, so CP0 can take it as EPC/BadVAddr.
- BD = is_branch_d, gated to 0 when req is high. ERET has no delay slot; the D-stage decoder keeps is_branch_d low for ERET.
- This block has no flush output. Squashing the IF/ID contents on req is the IF/ID register's responsibility.

## Timing
- While reset is low (asynchronous): pc_r = PC_RESET.
  - Outputs: pc = 32'h3000, i_inst_addr = 32'h3000, exc_code = 5'd31 with default parameters.
  - BD is forced to 0 while reset is low, regardless of is_branch_d.
- Release of reset takes effect at the first rising edge after reset goes high; there is no synchronizer inside this block.
- Latency: a next-PC decision in cycle n appears on pc/i_inst_addr after edge n+1. instruction, exc_code and BD are valid combinationally in the same cycle as pc.
- Taken branch in D at cycle n: the delay slot is fetched in cycle n with BD=1. The target appears in cycle n+1.
- Simultaneous events:
  - req + eret_flush: HANDLER_ADDR.
  - req + branch_taken: HANDLER_ADDR.
  - eret_flush + frozen: epc.
  - frozen + branch_taken: hold.
- Fetch exception while frozen: pc and exc_code=4 stay stable until unfrozen or req.
- Reset asserted mid-stall or mid-redirect: pc_r goes immediately to PC_RESET, and any pending decision is discarded.

## Test plan
- Reset, then release with all controls low for 3 cycles -> pc = 3000, 3004, 3008; exc_code = 31; BD = 0; instruction = memory word at pc.
- At pc=3008, raise is_branch_d=1, branch_taken=1, branch_target=3100 for one cycle -> that cycle BD=1 and pc=3008; next cycle pc=3100 with BD=0 once is_branch_d drops.
- frozen=1 for 2 cycles at pc=3010, with branch_taken=1 in the first cycle -> pc stays 3010 for both cycles; first unfrozen cycle with branch_taken=0 -> pc=3014.
- branch_target=3002 taken -> next pc=3002, exc_code=4, instruction=0; then req=1 -> next pc=4180, exc_code=31.
- At pc=7000 via a redirect -> exc_code=4 (above IM_HI). Same cycle eret_flush=1, epc=3020, frozen=1 -> next pc=3020.
- Pull reset low asynchronously between edges while pc=3100 and frozen=1 -> pc reads 3000 before the next edge; BD=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: owns the program counter, selects the next fetch address and
// flags illegal fetch addresses (AdEL) before the IF/ID register latches them.
module fetch_stage #(
   parameter logic [31:0] PC_RESET     = 32'h0000_3000,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] IM_LO        = 32'h0000_3000,
   parameter logic [31:0] IM_HI        = 32'h0000_6ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frozen,
   input  logic        req,
   input  logic        eret_flush,
   input  logic [31:0] epc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        is_branch_d,
   output logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [4:0]  exc_code,
   output logic        BD
);

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_NONE = 5'd31;

   typedef enum logic [2:0] {
      SRC_HANDLER,
      SRC_EPC,
      SRC_HOLD,
      SRC_BRANCH,
      SRC_SEQ
   } pc_src_e;

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] w_pc_seq;
   pc_src_e     w_src;
   logic        w_misaligned;
   logic        w_below;
   logic        w_above;
   logic        w_adel;

   // req and eret_flush must win over frozen so a stalled pipe can still trap/return
   always_comb begin
      w_src = SRC_SEQ;
      if (req)
         w_src = SRC_HANDLER;
      else if (eret_flush)
         w_src = SRC_EPC;
      else if (frozen)
         w_src = SRC_HOLD;
      else if (branch_taken)
         w_src = SRC_BRANCH;
   end

   assign w_pc_seq = r_pc + 32'd4;

   always_comb begin
      w_pc_next = w_pc_seq;
      case (w_src)
         SRC_HANDLER: w_pc_next = HANDLER_ADDR;
         SRC_EPC:     w_pc_next = epc;
         SRC_HOLD:    w_pc_next = r_pc;
         SRC_BRANCH:  w_pc_next = branch_target;
         default:     w_pc_next = w_pc_seq;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_pc <= PC_RESET;
      else
         r_pc <= w_pc_next;
   end

   // Wrap past 32'hffff_fffc lands far below IM_LO, so the range check covers it
   assign w_misaligned = (r_pc[1:0] != 2'b00);
   assign w_below      = (r_pc < IM_LO);
   assign w_above      = (r_pc > IM_HI);
   assign w_adel       = w_misaligned | w_below | w_above;

   assign i_inst_addr = r_pc;
   assign pc          = r_pc;
   assign instruction = w_adel ? '0 : i_inst_rdata;
   assign exc_code    = w_adel ? EXC_ADEL : EXC_NONE;
   assign BD          = is_branch_d & ~req & reset;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each row drives one cycle of controls and
// queues the PC/exception/instruction/BD expected for that cycle.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        frozen;
   logic        req;
   logic        eret_flush;
   logic [31:0] epc;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        is_branch_d;
   logic [31:0] i_inst_addr;
   logic [31:0] i_inst_rdata;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [4:0]  exc_code;
   logic        BD;

   always #5 clk = ~clk;

   // ctl = {rst_n, frozen, req, eret_flush, branch_taken, is_branch_d}
   typedef struct {
      logic [5:0]  ctl;
      logic [31:0] tgt;
      logic [31:0] ep;
      logic [31:0] pc;
      logic [4:0]  exc;
      logic        bd;
   } row_t;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  exc;
      logic [31:0] ins;
      logic        bd;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   assign i_inst_rdata = mem_word(i_inst_addr);

   fetch_stage #(
      .PC_RESET     (32'h0000_3000),
      .HANDLER_ADDR (32'h0000_4180),
      .IM_LO        (32'h0000_3000),
      .IM_HI        (32'h0000_6ffc)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .frozen        (frozen),
      .req           (req),
      .eret_flush    (eret_flush),
      .epc           (epc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .is_branch_d   (is_branch_d),
      .i_inst_addr   (i_inst_addr),
      .i_inst_rdata  (i_inst_rdata),
      .instruction   (instruction),
      .pc            (pc),
      .exc_code      (exc_code),
      .BD            (BD)
   );

   task automatic drive_row(input row_t r);
      exp_t e;
      @(negedge clk);
      {reset, frozen, req, eret_flush, branch_taken, is_branch_d} = r.ctl;
      branch_target = r.tgt;
      epc           = r.ep;
      e.pc  = r.pc;
      e.exc = r.exc;
      e.ins = (r.exc == 5'd4) ? 32'h0 : mem_word(r.pc);
      e.bd  = r.bd;
      sb.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      row_t rows[2];
      rows = '{'{6'b000001, 32'h0, 32'h0, 32'h3000, 5'd31, 1'b0},
               '{6'b000011, 32'h5000, 32'h0, 32'h3000, 5'd31, 1'b0}};
      foreach (rows[i]) begin
         exp_t e;
         drive_row(rows[i]);
         e = sb.pop_front();
         n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL reset row%0d pc: got %h want %h", i, pc, e.pc); end
         n_cmp++; if (i_inst_addr !== e.pc) begin n_err++; $display("FAIL reset row%0d addr: got %h want %h", i, i_inst_addr, e.pc); end
         n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL reset row%0d exc: got %0d want %0d", i, exc_code, e.exc); end
         n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL reset row%0d ins: got %h want %h", i, instruction, e.ins); end
         n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL reset row%0d bd: got %b want %b", i, BD, e.bd); end
      end
   endtask

   task automatic test_seq_and_branch();
      row_t rows[5];
      rows = '{'{6'b100000, 32'h0,    32'h0, 32'h3000, 5'd31, 1'b0},
               '{6'b100000, 32'h0,    32'h0, 32'h3004, 5'd31, 1'b0},
               '{6'b100011, 32'h3100, 32'h0, 32'h3008, 5'd31, 1'b1},
               '{6'b100000, 32'h0,    32'h0, 32'h3100, 5'd31, 1'b0},
               '{6'b100011, 32'h3010, 32'h0, 32'h3104, 5'd31, 1'b1}};
      foreach (rows[i]) begin
         exp_t e;
         drive_row(rows[i]);
         e = sb.pop_front();
         n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL branch row%0d pc: got %h want %h", i, pc, e.pc); end
         n_cmp++; if (i_inst_addr !== e.pc) begin n_err++; $display("FAIL branch row%0d addr: got %h want %h", i, i_inst_addr, e.pc); end
         n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL branch row%0d exc: got %0d want %0d", i, exc_code, e.exc); end
         n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL branch row%0d ins: got %h want %h", i, instruction, e.ins); end
         n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL branch row%0d bd: got %b want %b", i, BD, e.bd); end
      end
   endtask

   task automatic test_frozen();
      row_t rows[4];
      rows = '{'{6'b110011, 32'h3500, 32'h0, 32'h3010, 5'd31, 1'b1},
               '{6'b110000, 32'h0,    32'h0, 32'h3010, 5'd31, 1'b0},
               '{6'b100000, 32'h0,    32'h0, 32'h3010, 5'd31, 1'b0},
               '{6'b100000, 32'h0,    32'h0, 32'h3014, 5'd31, 1'b0}};
      foreach (rows[i]) begin
         exp_t e;
         drive_row(rows[i]);
         e = sb.pop_front();
         n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL frozen row%0d pc: got %h want %h", i, pc, e.pc); end
         n_cmp++; if (i_inst_addr !== e.pc) begin n_err++; $display("FAIL frozen row%0d addr: got %h want %h", i, i_inst_addr, e.pc); end
         n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL frozen row%0d exc: got %0d want %0d", i, exc_code, e.exc); end
         n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL frozen row%0d ins: got %h want %h", i, instruction, e.ins); end
         n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL frozen row%0d bd: got %b want %b", i, BD, e.bd); end
      end
   endtask

   task automatic test_exceptions();
      row_t rows[7];
      rows = '{'{6'b100011, 32'h3002, 32'h0,    32'h3018, 5'd31, 1'b1},
               '{6'b101011, 32'h3500, 32'h0,    32'h3002, 5'd4,  1'b0},
               '{6'b100000, 32'h0,    32'h0,    32'h4180, 5'd31, 1'b0},
               '{6'b100010, 32'h7000, 32'h0,    32'h4184, 5'd31, 1'b0},
               '{6'b110100, 32'h0,    32'h3020, 32'h7000, 5'd4,  1'b0},
               '{6'b101100, 32'h0,    32'h3040, 32'h3020, 5'd31, 1'b0},
               '{6'b100000, 32'h0,    32'h0,    32'h4180, 5'd31, 1'b0}};
      foreach (rows[i]) begin
         exp_t e;
         drive_row(rows[i]);
         e = sb.pop_front();
         n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL exc row%0d pc: got %h want %h", i, pc, e.pc); end
         n_cmp++; if (i_inst_addr !== e.pc) begin n_err++; $display("FAIL exc row%0d addr: got %h want %h", i, i_inst_addr, e.pc); end
         n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL exc row%0d exc: got %0d want %0d", i, exc_code, e.exc); end
         n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL exc row%0d ins: got %h want %h", i, instruction, e.ins); end
         n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL exc row%0d bd: got %b want %b", i, BD, e.bd); end
      end
   endtask

   task automatic test_boundaries();
      row_t rows[7];
      rows = '{'{6'b100010, 32'h6ffc,      32'h0, 32'h4184,      5'd31, 1'b0},
               '{6'b100000, 32'h0,         32'h0, 32'h6ffc,      5'd31, 1'b0},
               '{6'b100010, 32'hffff_fffc, 32'h0, 32'h7000,      5'd4,  1'b0},
               '{6'b100000, 32'h0,         32'h0, 32'hffff_fffc, 5'd4,  1'b0},
               '{6'b100010, 32'h2ffc,      32'h0, 32'h0,         5'd4,  1'b0},
               '{6'b100010, 32'h3001,      32'h0, 32'h2ffc,      5'd4,  1'b0},
               '{6'b100010, 32'h3100,      32'h0, 32'h3001,      5'd4,  1'b0}};
      foreach (rows[i]) begin
         exp_t e;
         drive_row(rows[i]);
         e = sb.pop_front();
         n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL bound row%0d pc: got %h want %h", i, pc, e.pc); end
         n_cmp++; if (i_inst_addr !== e.pc) begin n_err++; $display("FAIL bound row%0d addr: got %h want %h", i, i_inst_addr, e.pc); end
         n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL bound row%0d exc: got %0d want %0d", i, exc_code, e.exc); end
         n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL bound row%0d ins: got %h want %h", i, instruction, e.ins); end
         n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL bound row%0d bd: got %b want %b", i, BD, e.bd); end
      end
   endtask

   task automatic test_async_reset();
      row_t rows[3];
      exp_t e;
      rows = '{'{6'b110000, 32'h0, 32'h0, 32'h3100, 5'd31, 1'b0},
               '{6'b100000, 32'h0, 32'h0, 32'h3000, 5'd31, 1'b0},
               '{6'b100000, 32'h0, 32'h0, 32'h3004, 5'd31, 1'b0}};
      drive_row(rows[0]);
      e = sb.pop_front();
      n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL async pre pc: got %h want %h", pc, e.pc); end
      // pull reset low mid-cycle, well before the next rising edge
      #1;
      reset       = 1'b0;
      is_branch_d = 1'b1;
      e.pc  = 32'h3000;
      e.exc = 5'd31;
      e.ins = mem_word(32'h3000);
      e.bd  = 1'b0;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL async mid pc: got %h want %h", pc, e.pc); end
      n_cmp++; if (i_inst_addr !== e.pc) begin n_err++; $display("FAIL async mid addr: got %h want %h", i_inst_addr, e.pc); end
      n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL async mid exc: got %0d want %0d", exc_code, e.exc); end
      n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL async mid ins: got %h want %h", instruction, e.ins); end
      n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL async mid bd: got %b want %b", BD, e.bd); end
      for (int i = 1; i < 3; i++) begin
         drive_row(rows[i]);
         e = sb.pop_front();
         n_cmp++; if (pc !== e.pc) begin n_err++; $display("FAIL async row%0d pc: got %h want %h", i, pc, e.pc); end
         n_cmp++; if (exc_code !== e.exc) begin n_err++; $display("FAIL async row%0d exc: got %0d want %0d", i, exc_code, e.exc); end
         n_cmp++; if (instruction !== e.ins) begin n_err++; $display("FAIL async row%0d ins: got %h want %h", i, instruction, e.ins); end
         n_cmp++; if (BD !== e.bd) begin n_err++; $display("FAIL async row%0d bd: got %b want %b", i, BD, e.bd); end
      end
   endtask

   initial begin
      reset         = 1'b0;
      frozen        = 1'b0;
      req           = 1'b0;
      eret_flush    = 1'b0;
      epc           = '0;
      branch_taken  = 1'b0;
      branch_target = '0;
      is_branch_d   = 1'b0;
      test_reset();
      test_seq_and_branch();
      test_frozen();
      test_exceptions();
      test_boundaries();
      test_async_reset();
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
